// File: rtl/sparhixcel_pkg.sv
// rtl/sparhixcel_pkg.sv - shared sequencer state encoding and length-width helper
package sparhixcel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  // Length field must hold counts 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/mux_tr_sequencer_if.sv
// rtl/mux_tr_sequencer_if.sv - control/stream bundle between a transfer client and the sequencer
interface mux_tr_sequencer_if #(
  parameter int SEL_W = 4,
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             tr_ready;
  logic [SEL_W-1:0] sel_mux_tr;
  logic             sel_mux_tr_ld;
  logic             sel_mux_tr_rst;
  logic             tr_valid;
  logic             tr_last;
  logic             busy;
  logic             done;

  modport master (
    output start, len, abort, tr_ready,
    input  sel_mux_tr, sel_mux_tr_ld, sel_mux_tr_rst, tr_valid, tr_last, busy, done
  );

  modport slave (
    input  start, len, abort, tr_ready,
    output sel_mux_tr, sel_mux_tr_ld, sel_mux_tr_rst, tr_valid, tr_last, busy, done
  );
endinterface

// File: rtl/tr_index_counter.sv
// rtl/tr_index_counter.sv - entry index with clear/increment and last-entry detect
module tr_index_counter #(
  parameter int IDX_W = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             incr,
  input  logic [LEN_W-1:0] limit,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_next,
  output logic             tc
);
  localparam int SW = IDX_W + LEN_W;

  assign idx_next = idx + IDX_W'(1);
  // Terminal when idx == limit-1, compared at a common width so limit=0 never matches.
  assign tc = (SW'(idx) + SW'(1)) == SW'(limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (incr) begin
      idx <= idx_next;
    end
  end
endmodule

// File: rtl/mux_tr_sequencer.sv
// rtl/mux_tr_sequencer.sv - sweeps a mux select across eff_len entries with valid/ready pacing
module mux_tr_sequencer
  import sparhixcel_pkg::*;
#(
  parameter int LEN_TRANSFER     = 10,
  parameter int MAX_LEN_TRANSFER = 10,
  parameter int SEL_MUX_TR_WIDTH = $clog2(MAX_LEN_TRANSFER),
  parameter int LEN_WIDTH        = len_width(MAX_LEN_TRANSFER)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        start_i,
  input  logic [LEN_WIDTH-1:0]        len_i,
  input  logic                        abort_i,
  input  logic                        tr_ready_i,
  output logic [SEL_MUX_TR_WIDTH-1:0] sel_mux_tr_o,
  output logic                        sel_mux_tr_ld_o,
  output logic                        sel_mux_tr_rst_o,
  output logic                        tr_valid_o,
  output logic                        tr_last_o,
  output logic                        busy_o,
  output logic                        done_o
);
  seq_state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]        eff_len;
  logic [SEL_MUX_TR_WIDTH-1:0] idx, idx_next;
  logic                        idx_clear, idx_incr, idx_tc;

  tr_index_counter #(
    .IDX_W(SEL_MUX_TR_WIDTH),
    .LEN_W(LEN_WIDTH)
  ) u_index (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .clear   (idx_clear),
    .incr    (idx_incr),
    .limit   (eff_len),
    .idx     (idx),
    .idx_next(idx_next),
    .tc      (idx_tc)
  );

  assign tr_last_o = (state == STREAM) && idx_tc;

  always_comb begin
    state_nxt        = state;
    idx_clear        = 1'b0;
    idx_incr         = 1'b0;
    sel_mux_tr_o     = '0;
    sel_mux_tr_ld_o  = 1'b0;
    sel_mux_tr_rst_o = 1'b0;
    tr_valid_o       = 1'b0;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            idx_clear = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        busy_o = 1'b1;
        if (abort_i) begin
          sel_mux_tr_rst_o = 1'b1;
          state_nxt        = IDLE;
        end else begin
          sel_mux_tr_ld_o = 1'b1;
          state_nxt       = STREAM;
        end
      end
      STREAM: begin
        busy_o     = 1'b1;
        tr_valid_o = 1'b1;
        // Abort wins over a coincident handshake and swallows its load strobe.
        if (abort_i) begin
          sel_mux_tr_rst_o = 1'b1;
          state_nxt        = IDLE;
        end else if (tr_ready_i) begin
          if (idx_tc) begin
            state_nxt = DONE;
          end else begin
            sel_mux_tr_ld_o = 1'b1;
            sel_mux_tr_o    = idx_next;
            idx_incr        = 1'b1;
          end
        end
      end
      DONE: begin
        done_o           = 1'b1;
        sel_mux_tr_rst_o = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      eff_len <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_i && len_i != '0) begin
        eff_len <= (len_i > LEN_WIDTH'(LEN_TRANSFER)) ? LEN_WIDTH'(LEN_TRANSFER) : len_i;
      end
    end
  end
endmodule

// File: tb/tb_mux_tr_sequencer.sv
// tb/tb_mux_tr_sequencer.sv - directed self-checking bench for mux_tr_sequencer
module tb_mux_tr_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  mux_tr_sequencer_if #(.SEL_W(4), .LEN_W(4)) bus ();

  mux_tr_sequencer dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (bus.start),
    .len_i           (bus.len),
    .abort_i         (bus.abort),
    .tr_ready_i      (bus.tr_ready),
    .sel_mux_tr_o    (bus.sel_mux_tr),
    .sel_mux_tr_ld_o (bus.sel_mux_tr_ld),
    .sel_mux_tr_rst_o(bus.sel_mux_tr_rst),
    .tr_valid_o      (bus.tr_valid),
    .tr_last_o       (bus.tr_last),
    .busy_o          (bus.busy),
    .done_o          (bus.done)
  );

  always #5 clk = ~clk;

  // Expected vector order: busy, done, valid, last, ld, rst, sel[3:0]
  task automatic expect_out(input string tag, input logic b, input logic d, input logic v,
                            input logic l, input logic ld, input logic r, input logic [3:0] sel);
    logic [9:0] obs, exp;
    obs = {bus.busy, bus.done, bus.tr_valid, bus.tr_last, bus.sel_mux_tr_ld,
           bus.sel_mux_tr_rst, bus.sel_mux_tr};
    exp = {b, d, v, l, ld, r, sel};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] len, input logic a, input logic r);
    @(negedge clk);
    bus.start    = s;
    bus.len      = len;
    bus.abort    = a;
    bus.tr_ready = r;
    #1;
  endtask

  task automatic run_len4(input string tag);
    step(1, 4, 0, 1); expect_out({tag, "_idle"},  0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out({tag, "_load"},  1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1); expect_out({tag, "_e0"},    1, 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 1); expect_out({tag, "_e1"},    1, 0, 1, 0, 1, 0, 2);
    step(0, 0, 0, 1); expect_out({tag, "_e2"},    1, 0, 1, 0, 1, 0, 3);
    step(0, 0, 0, 1); expect_out({tag, "_e3"},    1, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1); expect_out({tag, "_done"},  0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1); expect_out({tag, "_back"},  0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.len = 0; bus.abort = 0; bus.tr_ready = 0;
    #1;
    expect_out("in_reset", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0); expect_out("reset_idle", 0, 0, 0, 0, 0, 0, 0);

    run_len4("len4");

    // len=3 with ready toggling; a start during the sweep must be ignored
    step(1, 3, 0, 1); expect_out("tog_idle",   0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("tog_load",   1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1); expect_out("tog_e0_hs",  1, 0, 1, 0, 1, 0, 1);
    step(1, 1, 0, 0); expect_out("tog_e1_st",  1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("tog_e1_hs",  1, 0, 1, 0, 1, 0, 2);
    step(0, 0, 0, 0); expect_out("tog_e2_st",  1, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("tog_e2_hs",  1, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0); expect_out("tog_done",   0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0); expect_out("tog_back",   0, 0, 0, 0, 0, 0, 0);

    // len=0 goes straight to DONE
    step(1, 0, 0, 1); expect_out("zero_idle",  0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("zero_done",  0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1); expect_out("zero_back",  0, 0, 0, 0, 0, 0, 0);

    // len=15 clamps to 10 entries
    step(1, 15, 0, 1); expect_out("clamp_idle", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1);  expect_out("clamp_load", 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 1);
      expect_out($sformatf("clamp_e%0d", i), 1, 0, 1, 0, 1, 0, 4'(i + 1));
    end
    step(0, 0, 0, 1); expect_out("clamp_e9",   1, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("clamp_done", 0, 1, 0, 0, 0, 1, 0);

    // abort at idx=2 with coincident handshake
    step(1, 5, 0, 1); expect_out("abt_idle",   0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("abt_load",   1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1); expect_out("abt_e0",     1, 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 1); expect_out("abt_e1",     1, 0, 1, 0, 1, 0, 2);
    step(0, 0, 1, 1); expect_out("abt_e2",     1, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1); expect_out("abt_idle1",  0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("abt_idle2",  0, 0, 0, 0, 0, 0, 0);

    // abort while in LOAD
    step(1, 2, 0, 1); expect_out("abl_idle",   0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1); expect_out("abl_load",   1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1); expect_out("abl_back",   0, 0, 0, 0, 0, 0, 0);

    // asynchronous reset mid-STREAM
    step(1, 4, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0); expect_out("rst_pre",    1, 0, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    expect_out("rst_async",  0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("rst_hold",   0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 1); expect_out("rst_post1",  0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("rst_post2",  0, 0, 0, 0, 0, 0, 0);
    run_len4("relen4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
